// File: rtl/md_audio_pkg.sv
// Shared types and helpers for the audio mixer: FSM states, accumulator sizing,
// unity-gain value and the output clamp.
package md_audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_SAT
  } mix_state_t;

  // One extra bit covers the unsigned gain's sign extension and keeps the sum exact.
  function automatic int acc_width(input int iw, input int gw, input int nch);
    return iw + gw + $clog2(nch) + 1;
  endfunction

  function automatic int unity_gain(input int gw);
    return 1 << (gw - 1);
  endfunction

  function automatic longint sat_clamp(input longint v, input int ow);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (ow - 1)) - longint'(1);
    lo = -hi - longint'(1);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/md_audio_sat.sv
// Combinational rescale of a mix accumulator: drop the gain fraction, apply the
// output shift, then clamp to the signed output range.
module md_audio_sat
  import md_audio_pkg::*;
#(
  parameter int AW     = 20,
  parameter int GW     = 8,
  parameter int OW     = 16,
  parameter int OSHIFT = 7
) (
  input  logic signed [AW-1:0] acc,
  output logic signed [OW-1:0] result
);

  longint shifted;
  longint clamped;

  always_comb begin
    shifted = (longint'(acc) >>> (GW - 1)) <<< OSHIFT;
    clamped = sat_clamp(shifted, OW);
    result  = clamped[OW-1:0];
  end

endmodule

// File: rtl/md_audio_mixer.sv
// Sequential multi-channel stereo mixer: one channel per cycle is scaled by its
// left/right gain and accumulated, then the sums are rescaled and clamped.
module md_audio_mixer
  import md_audio_pkg::*;
#(
  parameter int          NCH       = 4,
  parameter int          IW        = 9,
  parameter int          GW        = 8,
  parameter int          OW        = 16,
  parameter int          OSHIFT    = 7,
  parameter logic [15:0] OFFS_MASK = 16'h0003
) (
  input  logic                 MCLK,
  input  logic                 reset_n,
  input  logic [NCH*IW-1:0]    ch_data,
  input  logic                 smp_stb,
  input  logic                 gain_we,
  input  logic [$clog2(NCH):0] gain_sel,
  input  logic [GW-1:0]        gain_wdata,
  output logic                 gain_rdy,
  output logic signed [OW-1:0] out_l,
  output logic signed [OW-1:0] out_r,
  output logic                 out_valid,
  output logic                 overrun,
  input  logic                 overrun_clr
);

  localparam int AW = acc_width(IW, GW, NCH);
  localparam int SW = $clog2(NCH) + 1;
  localparam int XW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [GW-1:0] UNITY = GW'(unity_gain(GW));

  mix_state_t           state;
  logic [XW-1:0]        idx;
  logic [NCH*IW-1:0]    data_reg;
  logic signed [AW-1:0] acc_l;
  logic signed [AW-1:0] acc_r;
  logic [GW-1:0]        gain_l [NCH];
  logic [GW-1:0]        gain_r [NCH];

  logic [SW-1:0]        sel_ch;
  logic [IW-1:0]        raw;
  logic signed [IW-1:0] sample;
  logic signed [AW-1:0] prod_l;
  logic signed [AW-1:0] prod_r;
  logic signed [OW-1:0] sat_l;
  logic signed [OW-1:0] sat_r;

  assign gain_rdy = (state == ST_IDLE);
  assign sel_ch   = gain_sel >> 1;

  // Offset-binary to two's complement is just an MSB flip.
  always_comb begin
    raw    = data_reg[int'(idx)*IW +: IW];
    sample = OFFS_MASK[idx] ? $signed({~raw[IW-1], raw[IW-2:0]}) : $signed(raw);
    prod_l = AW'(sample) * AW'($signed({1'b0, gain_l[idx]}));
    prod_r = AW'(sample) * AW'($signed({1'b0, gain_r[idx]}));
  end

  always_ff @(posedge MCLK) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        gain_l[i] <= UNITY;
        gain_r[i] <= UNITY;
      end
    end else if (gain_we && state == ST_IDLE) begin
      for (int i = 0; i < NCH; i++) begin
        if (sel_ch == SW'(i)) begin
          if (gain_sel[0]) gain_r[i] <= gain_wdata;
          else             gain_l[i] <= gain_wdata;
        end
      end
    end
  end

  always_ff @(posedge MCLK) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      data_reg  <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      out_l     <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (smp_stb && state != ST_IDLE) overrun <= 1'b1;
      else if (overrun_clr)            overrun <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (smp_stb) begin
            data_reg <= ch_data;
            acc_l    <= '0;
            acc_r    <= '0;
            idx      <= '0;
            state    <= ST_ACC;
          end
        end
        ST_ACC: begin
          acc_l <= acc_l + prod_l;
          acc_r <= acc_r + prod_r;
          idx   <= idx + 1'b1;
          if (idx == XW'(NCH - 1)) state <= ST_SAT;
        end
        ST_SAT: begin
          out_l     <= sat_l;
          out_r     <= sat_r;
          out_valid <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  md_audio_sat #(.AW(AW), .GW(GW), .OW(OW), .OSHIFT(OSHIFT)) u_sat_l (
    .acc    (acc_l),
    .result (sat_l)
  );

  md_audio_sat #(.AW(AW), .GW(GW), .OW(OW), .OSHIFT(OSHIFT)) u_sat_r (
    .acc    (acc_r),
    .result (sat_r)
  );

endmodule

// File: tb/tb_md_audio_mixer.sv
// Self-checking bench: directed steps plus randomised mixes compared against an
// arithmetic reference model of the mixer.
module tb_md_audio_mixer;

  logic               MCLK = 1'b0;
  logic               reset_n;
  logic [35:0]        ch_data;
  logic               smp_stb;
  logic               gain_we;
  logic [2:0]         gain_sel;
  logic [7:0]         gain_wdata;
  logic               gain_rdy;
  logic signed [15:0] out_l;
  logic signed [15:0] out_r;
  logic               out_valid;
  logic               overrun;
  logic               overrun_clr;

  logic [15:0]        b_data;
  logic               b_stb;
  logic               b_gain_rdy;
  logic signed [15:0] b_out_l;
  logic signed [15:0] b_out_r;
  logic               b_out_valid;
  logic               b_overrun;

  int compared   = 0;
  int mismatched = 0;
  int gl [4];
  int gr [4];

  always #5 MCLK = ~MCLK;

  md_audio_mixer dut (
    .MCLK        (MCLK),
    .reset_n     (reset_n),
    .ch_data     (ch_data),
    .smp_stb     (smp_stb),
    .gain_we     (gain_we),
    .gain_sel    (gain_sel),
    .gain_wdata  (gain_wdata),
    .gain_rdy    (gain_rdy),
    .out_l       (out_l),
    .out_r       (out_r),
    .out_valid   (out_valid),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  md_audio_mixer #(.NCH(1), .IW(16), .GW(8), .OW(16), .OSHIFT(0), .OFFS_MASK(16'h0000)) dut_b (
    .MCLK        (MCLK),
    .reset_n     (reset_n),
    .ch_data     (b_data),
    .smp_stb     (b_stb),
    .gain_we     (1'b0),
    .gain_sel    (1'b0),
    .gain_wdata  (8'h00),
    .gain_rdy    (b_gain_rdy),
    .out_l       (b_out_l),
    .out_r       (b_out_r),
    .out_valid   (b_out_valid),
    .overrun     (b_overrun),
    .overrun_clr (1'b0)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge MCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: decode each channel, weight by gain/unity, floor, rescale, clamp.
  function automatic longint model(input logic [35:0] d, input bit left);
    longint sum = 0;
    longint q;
    for (int i = 0; i < 4; i++) begin
      int raw = int'(d[i*9 +: 9]);
      int v;
      if (i < 2)          v = raw - 256;
      else if (raw >= 256) v = raw - 512;
      else                 v = raw;
      sum += longint'(v) * longint'(left ? gl[i] : gr[i]);
    end
    q = sum / 128;
    if (sum < 0 && (sum % 128) != 0) q -= 1;
    q = q * 128;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  task automatic pend_gain(input int ch, input bit right, input int val);
    gain_we    = 1'b1;
    gain_sel   = 3'(ch * 2 + (right ? 1 : 0));
    gain_wdata = 8'(val);
    if (right) gr[ch] = val;
    else       gl[ch] = val;
  endtask

  task automatic write_gain(input int ch, input bit right, input int val);
    pend_gain(ch, right, val);
    step();
    gain_we = 1'b0;
  endtask

  task automatic mix(input string tag, input logic [35:0] d);
    longint el;
    longint er;
    int n;
    el = model(d, 1'b1);
    er = model(d, 1'b0);
    ch_data = d;
    smp_stb = 1'b1;
    step();
    smp_stb = 1'b0;
    gain_we = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    check({tag, "_lat"}, n, 6);
    check({tag, "_l"}, out_l, el);
    check({tag, "_r"}, out_r, er);
    $display("mix %s ch=%h latency=%0d out_l=%0d out_r=%0d", tag, d, n, out_l, out_r);
    step();
    check({tag, "_pulse"}, out_valid, 0);
    check({tag, "_hold"}, out_l, el);
  endtask

  initial begin
    int pulses;
    int n;
    logic [35:0] d;
    reset_n = 1'b0; ch_data = '0; smp_stb = 1'b0; gain_we = 1'b0;
    gain_sel = '0; gain_wdata = '0; overrun_clr = 1'b0;
    b_data = '0; b_stb = 1'b0;
    for (int i = 0; i < 4; i++) begin gl[i] = 128; gr[i] = 128; end
    step(); step();
    reset_n = 1'b1;
    check("rst_out_l", out_l, 0);
    check("rst_out_r", out_r, 0);
    check("rst_valid", out_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_rdy", gain_rdy, 1);

    mix("unity", {9'h000, 9'h000, 9'h100, 9'h1FF});
    check("unity_const", out_l, 32640);

    for (int i = 0; i < 4; i++) begin write_gain(i, 0, 255); write_gain(i, 1, 255); end
    mix("sat_pos", {9'h0FF, 9'h0FF, 9'h1FF, 9'h1FF});
    check("sat_pos_const", out_r, 32767);
    mix("sat_neg", {9'h100, 9'h100, 9'h000, 9'h000});
    check("sat_neg_const", out_l, -32768);

    for (int i = 0; i < 4; i++) begin write_gain(i, 0, 128); write_gain(i, 1, 128); end
    write_gain(0, 0, 8'h80);
    write_gain(0, 1, 8'h00);
    mix("pan", {9'h000, 9'h000, 9'h100, 9'h140});
    check("pan_l_const", out_l, 8192);
    check("pan_r_const", out_r, 0);

    // Strobe re-asserted two cycles into a mix is dropped and flagged.
    ch_data = 36'h0_1234_5678;
    smp_stb = 1'b1; step(); smp_stb = 1'b0; step();
    smp_stb = 1'b1; step(); smp_stb = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin step(); if (out_valid) pulses++; end
    check("ovr_pulses", pulses, 1);
    check("ovr_set", overrun, 1);
    $display("overrun event pulses=%0d overrun=%0d", pulses, overrun);
    overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
    check("ovr_clr", overrun, 0);
    smp_stb = 1'b1; step(); smp_stb = 1'b1; overrun_clr = 1'b1; step();
    smp_stb = 1'b0; overrun_clr = 1'b0;
    check("ovr_setwins", overrun, 1);
    for (int i = 0; i < 8; i++) step();
    overrun_clr = 1'b1; step(); overrun_clr = 1'b0;

    // Same-cycle gain write and strobe: mix sees the new gain.
    pend_gain(1, 0, 8'hC0);
    mix("gain_stb", {9'h055, 9'h1AA, 9'h1F0, 9'h133});

    // Gain write while busy is dropped.
    smp_stb = 1'b1; step(); smp_stb = 1'b0;
    gain_we = 1'b1; gain_sel = 3'd0; gain_wdata = 8'h20; step(); gain_we = 1'b0;
    for (int i = 0; i < 8; i++) step();
    mix("busy_we", {9'h011, 9'h0F0, 9'h0C0, 9'h1E0});

    // Reset in the middle of a mix.
    write_gain(2, 1, 8'h40);
    smp_stb = 1'b1; ch_data = 36'hF_FFFF_FFFF; step(); smp_stb = 1'b0; step();
    reset_n = 1'b0; step(); reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin gl[i] = 128; gr[i] = 128; end
    check("mid_rst_rdy", gain_rdy, 1);
    check("mid_rst_l", out_l, 0);
    check("mid_rst_r", out_r, 0);
    check("mid_rst_ovr", overrun, 0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin step(); if (out_valid) pulses++; end
    check("mid_rst_nopulse", pulses, 0);
    $display("reset in ACC pulses=%0d out_l=%0d", pulses, out_l);
    mix("post_rst", {9'h1C3, 9'h07E, 9'h1FF, 9'h003});

    for (int t = 0; t < 16; t++) begin
      write_gain($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 255));
      d = {4'($urandom), $urandom};
      if (t % 4 == 0) pend_gain($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 255));
      mix($sformatf("rnd%0d", t), d);
    end

    // Single-channel, 16-bit two's complement instance.
    b_data = 16'h8000; b_stb = 1'b1; step(); b_stb = 1'b0; n = 1;
    while (!b_out_valid && n < 40) begin step(); n++; end
    check("b_lat", n, 3);
    check("b_l", b_out_l, -32768);
    check("b_r", b_out_r, -32768);
    $display("mix nch1 ch=%h latency=%0d out_l=%0d", b_data, n, b_out_l);
    b_data = 16'h1234; b_stb = 1'b1; step(); b_stb = 1'b0; n = 1;
    while (!b_out_valid && n < 40) begin step(); n++; end
    check("b2_lat", n, 3);
    check("b2_l", b_out_l, 4660);
    $display("mix nch1 ch=%h latency=%0d out_l=%0d", b_data, n, b_out_l);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/md_audio_mixer.md
MD_AUDIO_MIXER -- requirements
Module: md_audio_mixer

Interface
REQ-001 SHALL have parameter NCH, default 4, number of input channels (1..16).
REQ-002 SHALL have parameter IW, default 9, input sample width.
REQ-003 SHALL have parameter GW, default 8, gain width: unsigned Q1.(GW-1), so 2^(GW-1) = unity.
REQ-004 SHALL have parameter OW, default 16, output width, signed.
REQ-005 SHALL have parameter OSHIFT, default 7, left shift applied before saturation.
REQ-006 SHALL have parameter OFFS_MASK, default 4'b0011; a set bit marks that channel as offset-binary, a clear bit as two's complement.
REQ-007 SHALL have port MCLK, in, 1, sole clock; all state updates on its rising edge.
REQ-008 SHALL have port reset_n, in, 1, reset; synchronous, active-low.
REQ-009 SHALL have port ch_data, in, NCH*IW, channel i samples occupying bits [i*IW +: IW].
REQ-010 SHALL have port smp_stb, in, 1, one-cycle request to mix one sample.
REQ-011 SHALL have port gain_we, in, 1, gain write strobe.
REQ-012 SHALL have port gain_sel, in, clog2(NCH)+1; LSB selects 0=left / 1=right, upper bits select the channel.
REQ-013 SHALL have port gain_wdata, in, GW, gain value.
REQ-014 SHALL have port gain_rdy, out, 1, high when IDLE.
REQ-015 SHALL have port out_l, out, OW; port out_r, out, OW; both signed mixed samples.
REQ-016 SHALL have port out_valid, out, 1, one-cycle pulse when out_l/out_r update.
REQ-017 SHALL have port overrun, out, 1, sticky flag: smp_stb was dropped.
REQ-018 SHALL have port overrun_clr, in, 1, clears overrun.

Function
REQ-019 SHALL implement an FSM with states IDLE, ACC, SAT.
- IDLE -> ACC on smp_stb.
- ACC -> SAT after channel NCH-1.
- SAT -> IDLE unconditionally.
REQ-020 On IDLE with smp_stb, SHALL latch all ch_data, clear acc_l/acc_r, and set idx=0.
REQ-021 In ACC, each cycle SHALL:
- convert channel idx to signed IW bits (offset-binary: subtract 2^(IW-1));
- add sample*gain_l[idx] to acc_l and sample*gain_r[idx] to acc_r;
- increment idx.
REQ-022 Accumulators SHALL be signed, IW+GW+clog2(NCH)+1 bits wide, with no intermediate overflow.
REQ-023 In SAT, SHALL compute (acc >>> (GW-1)) << OSHIFT with an arithmetic shift.
- Clamp the result to [-2^(OW-1), 2^(OW-1)-1].
- Register the result into out_l/out_r.
- Pulse out_valid.
REQ-024 Latency: smp_stb sampled at edge k SHALL give out_valid high in the cycle after edge k+NCH+1, i.e. NCH+2 cycles.
REQ-025 out_l/out_r SHALL hold their value between out_valid pulses.
REQ-026 smp_stb in ACC or SAT SHALL be ignored and SHALL set overrun at the next edge.
REQ-027 overrun_clr and an overrun event in the same cycle SHALL leave overrun=1 (set wins).
REQ-028 gain_we while gain_rdy=1 SHALL write the selected gain at the next edge.
REQ-029 gain_we while gain_rdy=0 SHALL be dropped silently, with no gain change.
REQ-030 gain_we with a channel index >= NCH SHALL be ignored.
REQ-031 gain_we and smp_stb in the same IDLE cycle SHALL both act; the mix SHALL use the new gain.
REQ-032 NCH=1 SHALL be legal: ACC lasts exactly one cycle.

Reset
REQ-033 reset_n=0 at an edge SHALL force the following, regardless of state, with any in-flight mix discarded:
- state=IDLE, idx=0, acc_l/acc_r=0;
- out_l/out_r=0, out_valid=0, overrun=0;
- all gains = 2^(GW-1) (unity).
REQ-034 The first smp_stb after reset_n rises SHALL be accepted normally.

Structure
REQ-035 A shared package md_audio_pkg SHALL hold:
- the FSM state enum;
- the accumulator-width function;
- the unity-gain constant function;
- the saturation function.
REQ-036 One sub-module, md_audio_sat (parametrised shift-and-clamp, combinational), SHALL be instantiated twice (L, R).
REQ-037 Gains SHALL be 2*NCH flop registers.

Verification (defaults unless stated)
REQ-038 Reset, unity gains, ch0=9'h1FF, other offset channels=9'h100, others=0, smp_stb -> out_valid after 6 cycles, out_l=out_r=16'sd32640.
REQ-039 Saturation: ch0=ch1=9'h1FF, ch2=ch3=9'h0FF, all gains 8'hFF -> out_l=out_r=32767; repeat with ch0=ch1=9'h000, ch2=ch3=9'h100 -> -32768.
REQ-040 Pan: gain_l[0]=8'h80, gain_r[0]=8'h00, ch0=9'h140, others zero-valued -> out_l=8192, out_r=0.
REQ-041 smp_stb asserted 2 cycles after a valid strobe -> single out_valid, overrun=1; overrun_clr -> overrun=0; simultaneous clr+event -> overrun=1.
REQ-042 reset_n low in ACC -> next cycle IDLE, out_valid never pulses, outputs 0; gain_we while busy -> gain unchanged on next mix.
REQ-043 NCH=1, IW=16, OFFS_MASK=0 instance: ch0=16'sh8000, unity gain, OSHIFT=0 -> out_l=-32768 after 3 cycles.
